// File: rtl/ps2_key_sequencer.sv
// ps2_key_sequencer: buffers ASCII characters in a small FIFO and plays each one
// out as a PS/2 set-2 make/break byte sequence (Left-Shift wrapped for uppercase)
// through the transmitter's req/busy handshake.
module ps2_key_sequencer #(
  parameter int FIFO_AW      = 3,
  parameter int GAP_CYCLES   = 25000,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic       clk_25mhz,
  input  logic       reset,
  input  logic [7:0] char_in,
  input  logic       char_valid,
  output logic       ps2_req,
  output logic [7:0] ps2_byte,
  input  logic       ps2_busy,
  output logic       fifo_full,
  output logic       idle,
  output logic       overflow,
  output logic       unknown
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int GW    = $clog2(GAP_CYCLES + 1);
  localparam int TW    = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SEND, S_WAIT_HI, S_WAIT_LO, S_GAP
  } state_t;

  state_t           state, state_nxt;
  logic [7:0]       mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic             empty, full, empty_nxt, full_nxt, push, pop;
  logic [7:0]       head;
  logic [7:0]       lk_code;
  logic             lk_shift, lk_hit;
  logic [7:0]       code_q, code_nxt;
  logic             shift_q, shift_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [TW-1:0]    tmr, tmr_nxt;
  logic [GW-1:0]    gap, gap_nxt;
  logic             unk_nxt, last;

  // Set-2 make code for letter offset 0 ('a') .. 25 ('z').
  function automatic logic [7:0] letter_code(input logic [7:0] off);
    case (off)
      8'd0:  letter_code = 8'h1C;  8'd1:  letter_code = 8'h32;
      8'd2:  letter_code = 8'h21;  8'd3:  letter_code = 8'h23;
      8'd4:  letter_code = 8'h24;  8'd5:  letter_code = 8'h2B;
      8'd6:  letter_code = 8'h34;  8'd7:  letter_code = 8'h33;
      8'd8:  letter_code = 8'h43;  8'd9:  letter_code = 8'h3B;
      8'd10: letter_code = 8'h42;  8'd11: letter_code = 8'h4B;
      8'd12: letter_code = 8'h3A;  8'd13: letter_code = 8'h31;
      8'd14: letter_code = 8'h44;  8'd15: letter_code = 8'h4D;
      8'd16: letter_code = 8'h15;  8'd17: letter_code = 8'h2D;
      8'd18: letter_code = 8'h1B;  8'd19: letter_code = 8'h2C;
      8'd20: letter_code = 8'h3C;  8'd21: letter_code = 8'h2A;
      8'd22: letter_code = 8'h1D;  8'd23: letter_code = 8'h22;
      8'd24: letter_code = 8'h35;  8'd25: letter_code = 8'h1A;
      default: letter_code = 8'h00;
    endcase
  endfunction

  // Byte at position i of the keystroke sequence for (code, shift).
  function automatic logic [7:0] seq_byte(input logic [2:0] i, input logic [7:0] c,
                                          input logic sh);
    if (!sh) begin
      seq_byte = (i == 3'd1) ? 8'hF0 : c;
    end else begin
      case (i)
        3'd0, 3'd5: seq_byte = 8'h12;
        3'd2, 3'd4: seq_byte = 8'hF0;
        default:    seq_byte = c;
      endcase
    end
  endfunction

  // FIFO flags; fullness is judged on the pointers at the start of the cycle,
  // so a same-cycle pop never makes room for a push.
  always_comb begin
    empty     = (wr_ptr == rd_ptr);
    full      = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
    push      = char_valid && !full;
    pop       = (state == S_LOAD);
    wr_nxt    = wr_ptr + {{FIFO_AW{1'b0}}, push};
    rd_nxt    = rd_ptr + {{FIFO_AW{1'b0}}, pop};
    empty_nxt = (wr_nxt == rd_nxt);
    full_nxt  = (wr_nxt[FIFO_AW] != rd_nxt[FIFO_AW]) &&
                (wr_nxt[FIFO_AW-1:0] == rd_nxt[FIFO_AW-1:0]);
    head      = mem[rd_ptr[FIFO_AW-1:0]];
  end

  // FIFO storage; contents need no reset, the pointers define validity.
  always_ff @(posedge clk_25mhz) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= char_in;
  end

  // ASCII -> set-2 code lookup on the FIFO head.
  always_comb begin
    lk_code  = 8'h00;
    lk_shift = 1'b0;
    lk_hit   = 1'b1;
    if (head >= 8'h61 && head <= 8'h7A) begin
      lk_code = letter_code(head - 8'h61);
    end else if (head >= 8'h41 && head <= 8'h5A) begin
      lk_code  = letter_code(head - 8'h41);
      lk_shift = 1'b1;
    end else begin
      case (head)
        8'h30: lk_code = 8'h45;  8'h31: lk_code = 8'h16;
        8'h32: lk_code = 8'h1E;  8'h33: lk_code = 8'h26;
        8'h34: lk_code = 8'h25;  8'h35: lk_code = 8'h2E;
        8'h36: lk_code = 8'h36;  8'h37: lk_code = 8'h3D;
        8'h38: lk_code = 8'h3E;  8'h39: lk_code = 8'h46;
        8'h20: lk_code = 8'h29;  8'h0D: lk_code = 8'h5A;
        8'h60: lk_code = 8'h0E;  8'h2D: lk_code = 8'h4E;
        8'h3D: lk_code = 8'h55;  8'h5B: lk_code = 8'h54;
        8'h5D: lk_code = 8'h5B;  8'h3B: lk_code = 8'h4C;
        8'h27: lk_code = 8'h52;  8'h2C: lk_code = 8'h41;
        8'h2E: lk_code = 8'h49;  8'h2F: lk_code = 8'h4A;
        8'h5C: lk_code = 8'h5D;
        default: lk_hit = 1'b0;
      endcase
    end
  end

  // Sequencer next-state: one character at a time, one byte per SEND.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    code_nxt  = code_q;
    shift_nxt = shift_q;
    tmr_nxt   = tmr;
    gap_nxt   = gap;
    unk_nxt   = 1'b0;
    last      = shift_q ? (idx == 3'd5) : (idx == 3'd2);
    case (state)
      S_IDLE: if (!empty) state_nxt = S_LOAD;
      S_LOAD: begin
        code_nxt  = lk_code;
        shift_nxt = lk_shift;
        idx_nxt   = 3'd0;
        if (lk_hit) state_nxt = S_SEND;
        else begin
          unk_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_SEND: begin
        tmr_nxt   = '0;
        state_nxt = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        gap_nxt = '0;
        // A transmitter that never acknowledges must not stall the sequence.
        if (ps2_busy) state_nxt = S_WAIT_LO;
        else if (tmr == TW'(BUSY_TIMEOUT - 1)) state_nxt = S_GAP;
        else tmr_nxt = tmr + TW'(1);
      end
      S_WAIT_LO: begin
        gap_nxt = '0;
        if (!ps2_busy) state_nxt = S_GAP;
      end
      S_GAP: begin
        if (gap == GW'(GAP_CYCLES - 1)) begin
          if (last) state_nxt = S_IDLE;
          else begin
            idx_nxt   = idx + 3'd1;
            state_nxt = S_SEND;
          end
        end else begin
          gap_nxt = gap + GW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, FIFO pointers and registered outputs. req/byte are loaded on entry
  // to SEND so the byte is valid in the req cycle and held until the next req.
  always_ff @(posedge clk_25mhz) begin
    if (reset) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      idx       <= 3'd0;
      code_q    <= 8'h00;
      shift_q   <= 1'b0;
      tmr       <= '0;
      gap       <= '0;
      ps2_req   <= 1'b0;
      ps2_byte  <= 8'h00;
      overflow  <= 1'b0;
      unknown   <= 1'b0;
      fifo_full <= 1'b0;
      idle      <= 1'b1;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_nxt;
      rd_ptr    <= rd_nxt;
      idx       <= idx_nxt;
      code_q    <= code_nxt;
      shift_q   <= shift_nxt;
      tmr       <= tmr_nxt;
      gap       <= gap_nxt;
      ps2_req   <= (state_nxt == S_SEND);
      if (state_nxt == S_SEND) ps2_byte <= seq_byte(idx_nxt, code_nxt, shift_nxt);
      overflow  <= char_valid && full;
      unknown   <= unk_nxt;
      fifo_full <= full_nxt;
      idle      <= (state_nxt == S_IDLE) && empty_nxt;
    end
  end

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Bench for ps2_key_sequencer: directed + randomized characters, a keystroke
// reference model built from lookup tables, and a behavioural transmitter.
module tb_ps2_key_sequencer;
  localparam int G = 20;
  localparam int T = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] char_in;
  logic       char_valid;
  logic       ps2_req;
  logic [7:0] ps2_byte;
  logic       ps2_busy;
  logic       fifo_full, idle, overflow, unknown;

  ps2_key_sequencer #(.FIFO_AW(3), .GAP_CYCLES(G), .BUSY_TIMEOUT(T)) dut (
    .clk_25mhz(clk), .reset(reset), .char_in(char_in), .char_valid(char_valid),
    .ps2_req(ps2_req), .ps2_byte(ps2_byte), .ps2_busy(ps2_busy),
    .fifo_full(fifo_full), .idle(idle), .overflow(overflow), .unknown(unknown)
  );

  always #5 clk = ~clk;

  int cmp = 0, errs = 0;
  logic [7:0] exp_q[$];
  int  req_cycs[$];
  int  exp_unk = 0, unk_cnt = 0, ov_cnt = 0, req_total = 0;
  int  mcyc = 0, fall_cyc = 0, last_req_cyc = 0;
  bit  prev_busy = 0, no_busy = 0;

  logic [7:0] lut_code [256];
  bit         lut_hit  [256];
  bit         lut_shift[256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Keystroke model: what the host should see on the wire for character c.
  task automatic model_add(input logic [7:0] c);
    logic [7:0] k;
    k = lut_code[c];
    if (!lut_hit[c]) exp_unk++;
    else if (lut_shift[c]) begin
      exp_q.push_back(8'h12); exp_q.push_back(k); exp_q.push_back(8'hF0);
      exp_q.push_back(k); exp_q.push_back(8'hF0); exp_q.push_back(8'h12);
    end else begin
      exp_q.push_back(k); exp_q.push_back(8'hF0); exp_q.push_back(k);
    end
  endtask

  // Caller sits #1 after a posedge; returns #1 after the push edge.
  task automatic push(input logic [7:0] c, input bit accepted);
    char_in = c; char_valid = 1'b1;
    if (accepted) model_add(c);
    @(posedge clk); #1;
    char_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int lim);
    int n = 0;
    while (!(idle === 1'b1 && exp_q.size() == 0) && n < lim) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_drained"}, 32'(n < lim), 32'd1);
    chk({tag, "_unknown_cnt"}, 32'(unk_cnt), 32'(exp_unk));
  endtask

  task automatic wait_reqs(input int target);
    int n = 0;
    while (req_total < target && n < 3000) begin @(posedge clk); #1; n++; end
    chk("wait_req", 32'(n < 3000), 32'd1);
  endtask

  // Transmitter: busy rises 2 cycles after req and holds for 100 cycles.
  initial begin
    ps2_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (ps2_req === 1'b1 && !no_busy) begin
        repeat (2) @(posedge clk);
        #1 ps2_busy = 1'b1;
        repeat (100) @(posedge clk);
        #1 ps2_busy = 1'b0;
      end
    end
  end

  // Wire monitor: every req byte is matched against the model in order.
  initial begin
    forever begin
      @(negedge clk);
      mcyc++;
      if (prev_busy && ps2_busy === 1'b0) fall_cyc = mcyc;
      prev_busy = (ps2_busy === 1'b1);
      if (overflow === 1'b1) ov_cnt++;
      if (unknown === 1'b1) unk_cnt++;
      if (ps2_req === 1'b1) begin
        req_total++;
        req_cycs.push_back(mcyc);
        chk("req_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("ps2_byte", 32'(ps2_byte), 32'(exp_q.pop_front()));
        if (!no_busy && last_req_cyc > 0 && fall_cyc > last_req_cyc)
          chk("gap_after_busy", 32'(mcyc - fall_cyc >= G), 32'd1);
        last_req_cyc = mcyc;
      end
    end
  end

  initial begin
    string      letters = "abcdefghijklmnopqrstuvwxyz";
    string      punct   = " `-=[];',./\\";
    string      pool    = "azQM05 9.,/;'[]=-\\`Kx";
    logic [7:0] let_codes[26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,
                                  8'h43,8'h3B,8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,
                                  8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,
                                  8'h35,8'h1A};
    logic [7:0] dig_codes[10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,
                                  8'h3E,8'h46};
    logic [7:0] pun_codes[12] = '{8'h29,8'h0E,8'h4E,8'h55,8'h54,8'h5B,8'h4C,8'h52,
                                  8'h41,8'h49,8'h4A,8'h5D};
    logic [7:0] c;
    int base, ov0, nq;

    for (int i = 0; i < 256; i++) begin
      lut_code[i] = 8'h00; lut_hit[i] = 0; lut_shift[i] = 0;
    end
    for (int i = 0; i < 26; i++) begin
      lut_code[letters[i]] = let_codes[i]; lut_hit[letters[i]] = 1;
      lut_code[letters[i] - 8'h20] = let_codes[i]; lut_hit[letters[i] - 8'h20] = 1;
      lut_shift[letters[i] - 8'h20] = 1;
    end
    for (int i = 0; i < 10; i++) begin
      lut_code[8'h30 + i] = dig_codes[i]; lut_hit[8'h30 + i] = 1;
    end
    for (int i = 0; i < 12; i++) begin
      lut_code[punct[i]] = pun_codes[i]; lut_hit[punct[i]] = 1;
    end
    lut_code[8'h0D] = 8'h5A; lut_hit[8'h0D] = 1;

    // Reset state
    reset = 1'b1; char_in = 8'h00; char_valid = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_req", 32'(ps2_req), 32'd0);
    chk("rst_byte", 32'(ps2_byte), 32'h00);
    chk("rst_full", 32'(fifo_full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_unk", 32'(unknown), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // 'a': req lands in the third cycle after the push cycle
    base = req_total;
    push("a", 1);
    chk("lat_idle_drop", 32'(idle), 32'd0);
    chk("lat_req_c1", 32'(ps2_req), 32'd0);
    @(posedge clk); #1;
    chk("lat_req_c2", 32'(ps2_req), 32'd0);
    @(posedge clk); #1;
    chk("lat_req_c3", 32'(ps2_req), 32'd1);
    chk("lat_byte", 32'(ps2_byte), 32'h1C);
    @(posedge clk); #1;
    chk("req_one_cycle", 32'(ps2_req), 32'd0);
    drain("a", 3000);
    chk("a_req_count", 32'(req_total - base), 32'd3);

    // 'Z': shift-wrapped
    base = req_total;
    push("Z", 1);
    drain("Z", 5000);
    chk("Z_req_count", 32'(req_total - base), 32'd6);

    // CR then 'x' back-to-back
    push(8'h0D, 1); push("x", 1);
    drain("cr_x", 5000);

    // 10 chars in consecutive cycles while the sequencer is mid-byte
    push("a", 1);
    wait_reqs(req_total + 1);
    ov0 = ov_cnt;
    for (int i = 0; i < 10; i++) begin
      c = pool[$urandom_range(0, pool.len() - 1)];
      push(c, i < 8);
      if (i == 6) chk("full_at_7", 32'(fifo_full), 32'd0);
      if (i == 7) chk("full_at_8", 32'(fifo_full), 32'd1);
    end
    repeat (2) @(posedge clk); #1;
    chk("overflow_pulses", 32'(ov_cnt - ov0), 32'd2);
    drain("burst", 20000);

    // unmapped '~' then '1'
    base = req_total;
    push("~", 1); push("1", 1);
    drain("tilde_1", 3000);
    chk("tilde_1_reqs", 32'(req_total - base), 32'd3);

    // randomized pairs, including arbitrary bytes
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 3) == 0) c = 8'($urandom_range(0, 255));
        else c = pool[$urandom_range(0, pool.len() - 1)];
        push(c, 1);
      end
      drain("rand", 6000);
    end

    // silent transmitter: each byte advances after SEND + timeout + gap
    no_busy = 1;
    nq = req_cycs.size();
    push("c", 1);
    drain("nobusy", 3000);
    chk("nobusy_reqs", 32'(req_cycs.size() - nq), 32'd3);
    if (req_cycs.size() - nq == 3) begin
      chk("nobusy_int1", 32'(req_cycs[nq + 1] - req_cycs[nq]), 32'(1 + T + G));
      chk("nobusy_int2", 32'(req_cycs[nq + 2] - req_cycs[nq + 1]), 32'(1 + T + G));
    end
    no_busy = 0;
    repeat (5) @(posedge clk); #1;

    // reset after the second byte of 'Q', with 'b' still queued
    base = req_total;
    push("Q", 1); push("b", 1);
    wait_reqs(base + 2);
    repeat (5) @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("mid_rst_idle", 32'(idle), 32'd1);
    chk("mid_rst_req", 32'(ps2_req), 32'd0);
    chk("mid_rst_byte", 32'(ps2_byte), 32'h00);
    chk("mid_rst_full", 32'(fifo_full), 32'd0);
    exp_q.delete();
    base = req_total;
    repeat (300) @(posedge clk); #1;
    chk("no_req_after_rst", 32'(req_total), 32'(base));
    chk("still_idle", 32'(idle), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
